dmx_frame_ctrl: RTL and testbench

//  Frame-level controller behind the DMX receiver. Takes the receiver's {channel, data, write_strobe}

---
 rtl/dmx_pkg.sv | 16 +
 rtl/dmx_bank_ram.sv | 34 +++
 rtl/dmx_frame_ctrl.sv | 171 +++++++++++++++++
 tb/tb_dmx_frame_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmx_pkg.sv
// Shared definitions for the DMX frame controller: FSM encodings and protocol constants.
package dmx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_SKIP = 2'd2
    } dmx_state_t;

    // Start code of a plain dimmer-data frame; anything else (RDM, text) is skipped.
    localparam logic [7:0] DMX_START_CODE_DIM = 8'h00;

    // 1 ms of silence at 24 MHz ends a frame.
    localparam int DMX_IDLE_TIMEOUT = 24000;

endpackage

// File: rtl/dmx_bank_ram.sv
// Two-bank channel buffer: one write port, one registered read port, addressed {bank, channel}.
module dmx_bank_ram #(
    parameter int CH_BITS = 9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [CH_BITS:0]   wr_addr,
    input  logic [7:0]         wr_data,
    input  logic               rd_en,
    input  logic [CH_BITS:0]   rd_addr,
    output logic [7:0]         rd_data
);

    localparam int DEPTH = 2 ** (CH_BITS + 1);

    logic [7:0] mem_reg [0:DEPTH-1];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Only the output register is reset; the array contents survive reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_reg[rd_addr];
        end
    end

endmodule

// File: rtl/dmx_frame_ctrl.sv
// Frame controller: fills the back bank from the DMX receiver, swaps banks on frame completion,
// and round-robin arbitrates two readers of the front bank.
module dmx_frame_ctrl
    import dmx_pkg::*;
#(
    parameter int MAX_CHANNEL_BITS = 8,
    parameter int IDLE_TIMEOUT     = DMX_IDLE_TIMEOUT,
    parameter int TIMER_BITS       = 15
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [MAX_CHANNEL_BITS:0] rx_channel,
    input  logic [7:0]                rx_data,
    input  logic                      rx_strobe,
    input  logic [1:0]                rd_req,
    input  logic [MAX_CHANNEL_BITS:0] rd_addr0,
    input  logic [MAX_CHANNEL_BITS:0] rd_addr1,
    output logic [1:0]                rd_grant,
    output logic [7:0]                rd_data,
    output logic [1:0]                rd_valid,
    output logic                      frame_valid,
    output logic [MAX_CHANNEL_BITS:0] frame_len,
    output logic                      frame_swap
);

    localparam int CW = MAX_CHANNEL_BITS + 1;
    localparam logic [TIMER_BITS-1:0] TIMEOUT_VAL = TIMER_BITS'(IDLE_TIMEOUT);

    dmx_state_t          state_reg, state_next;
    logic [CW-1:0]       max_ch_reg, max_ch_next;
    logic [TIMER_BITS-1:0] timer_reg;
    logic                front_bank_reg;
    logic                frame_valid_reg;
    logic [CW-1:0]       frame_len_reg;
    logic                rr_ptr_reg;
    logic [1:0]          rd_valid_reg;

    logic                is_start;
    logic                dim_start;
    logic                timeout;
    logic                commit;
    logic                ram_we;
    logic                wr_bank;
    logic [1:0]          grant;
    logic [CW-1:0]       rd_addr_arr [2];
    logic [CW-1:0]       addr_masked [2];
    logic [CW-1:0]       rd_sel_addr;

    assign is_start  = rx_strobe && (rx_channel == '0);
    assign dim_start = is_start && (rx_data == DMX_START_CODE_DIM);
    // A strobe always beats a coincident timeout.
    assign timeout   = (timer_reg == TIMEOUT_VAL) && !rx_strobe;

    always_comb begin
        state_next  = state_reg;
        max_ch_next = max_ch_reg;
        ram_we      = 1'b0;
        commit      = 1'b0;
        if (is_start) begin
            // Start-code-only frames are dropped rather than swapped in.
            if (state_reg == ST_RECV) begin
                commit = (max_ch_reg != '0);
            end
            if (dim_start) begin
                state_next  = ST_RECV;
                max_ch_next = '0;
                ram_we      = 1'b1;
            end else begin
                state_next = ST_SKIP;
            end
        end else begin
            case (state_reg)
                ST_RECV: begin
                    if (rx_strobe) begin
                        ram_we = 1'b1;
                        if (rx_channel > max_ch_reg) begin
                            max_ch_next = rx_channel;
                        end
                    end else if (timeout) begin
                        commit     = (max_ch_reg != '0);
                        state_next = ST_IDLE;
                    end
                end
                ST_SKIP: begin
                    if (timeout) begin
                        state_next = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // On a swap the triggering start-code write lands in the bank that is about to become back.
    assign wr_bank = commit ? front_bank_reg : ~front_bank_reg;

    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (rd_req == 2'b11) begin
                grant = rr_ptr_reg ? 2'b10 : 2'b01;
            end else begin
                grant = rd_req;
            end
        end
    end

    assign rd_addr_arr[0] = rd_addr0;
    assign rd_addr_arr[1] = rd_addr1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd_mux
            assign addr_masked[gi] = grant[gi] ? rd_addr_arr[gi] : '0;
        end
    endgenerate

    assign rd_sel_addr = addr_masked[0] | addr_masked[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= ST_IDLE;
            max_ch_reg      <= '0;
            timer_reg       <= '0;
            front_bank_reg  <= 1'b0;
            frame_valid_reg <= 1'b0;
            frame_len_reg   <= '0;
            rr_ptr_reg      <= 1'b0;
            rd_valid_reg    <= 2'b00;
        end else begin
            state_reg    <= state_next;
            max_ch_reg   <= max_ch_next;
            rd_valid_reg <= grant;
            if (rx_strobe) begin
                timer_reg <= '0;
            end else if (timer_reg != TIMEOUT_VAL) begin
                timer_reg <= timer_reg + 1'b1;
            end
            if (commit) begin
                front_bank_reg  <= ~front_bank_reg;
                frame_len_reg   <= max_ch_reg;
                frame_valid_reg <= 1'b1;
            end
            if (grant[0]) begin
                rr_ptr_reg <= 1'b1;
            end else if (grant[1]) begin
                rr_ptr_reg <= 1'b0;
            end
        end
    end

    dmx_bank_ram #(
        .CH_BITS (CW)
    ) u_bank_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (ram_we && !reset),
        .wr_addr ({wr_bank, rx_channel}),
        .wr_data (rx_data),
        .rd_en   (|grant),
        .rd_addr ({front_bank_reg, rd_sel_addr}),
        .rd_data (rd_data)
    );

    assign rd_grant    = grant;
    assign rd_valid    = rd_valid_reg;
    assign frame_valid = frame_valid_reg;
    assign frame_len   = frame_len_reg;
    assign frame_swap  = commit && !reset;

endmodule

// File: tb/tb_dmx_frame_ctrl.sv
// Directed bench for dmx_frame_ctrl: frame capture, bank swaps, skipped frames, arbitration, reset.
module tb_dmx_frame_ctrl;
    import dmx_pkg::*;

    localparam int MCB = 8;
    localparam int CW  = MCB + 1;
    localparam int TO  = 200;

    logic          clock = 1'b0;
    logic          reset;
    logic [CW-1:0] rx_channel;
    logic [7:0]    rx_data;
    logic          rx_strobe;
    logic [1:0]    rd_req;
    logic [CW-1:0] rd_addr0;
    logic [CW-1:0] rd_addr1;
    logic [1:0]    rd_grant;
    logic [7:0]    rd_data;
    logic [1:0]    rd_valid;
    logic          frame_valid;
    logic [CW-1:0] frame_len;
    logic          frame_swap;

    int errors   = 0;
    int checks   = 0;
    int swap_cnt = 0;

    dmx_frame_ctrl #(
        .MAX_CHANNEL_BITS (MCB),
        .IDLE_TIMEOUT     (TO),
        .TIMER_BITS       (15)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_channel  (rx_channel),
        .rx_data     (rx_data),
        .rx_strobe   (rx_strobe),
        .rd_req      (rd_req),
        .rd_addr0    (rd_addr0),
        .rd_addr1    (rd_addr1),
        .rd_grant    (rd_grant),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .frame_swap  (frame_swap)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (frame_swap === 1'b1) swap_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-24s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic strobe(input int ch, input logic [7:0] data, input logic exp_swap);
        rx_channel = CW'(ch);
        rx_data    = data;
        rx_strobe  = 1'b1;
        @(negedge clock);
        chk($sformatf("swap@ch%0d=%02h", ch, data), 16'(frame_swap), 16'(exp_swap));
        @(posedge clock);
        #1;
        rx_strobe = 1'b0;
    endtask

    task automatic read(input int r, input int addr, input logic [7:0] exp);
        logic [1:0] oh;
        oh = (r == 0) ? 2'b01 : 2'b10;
        if (r == 0) rd_addr0 = CW'(addr);
        else        rd_addr1 = CW'(addr);
        rd_req = oh;
        @(negedge clock);
        chk($sformatf("grant r%0d", r), 16'(rd_grant), 16'(oh));
        @(posedge clock);
        #1;
        rd_req = 2'b00;
        chk($sformatf("valid r%0d", r), 16'(rd_valid), 16'(oh));
        chk($sformatf("data r%0d a%0d", r, addr), 16'(rd_data), 16'(exp));
    endtask

    // Called in the cycle right after the last strobe, where the idle timer reads 0.
    task automatic wait_timeout(input logic exp_swap);
        step(TO - 1);
        @(negedge clock);
        chk("swap before timeout", 16'(frame_swap), 16'd0);
        step(1);
        @(negedge clock);
        chk("swap at timeout", 16'(frame_swap), 16'(exp_swap));
        step(1);
    endtask

    initial begin
        reset      = 1'b1;
        rx_strobe  = 1'b0;
        rx_channel = '0;
        rx_data    = '0;
        rd_req     = 2'b11;
        rd_addr0   = '0;
        rd_addr1   = '0;
        step(3);
        @(negedge clock);
        chk("reset rd_grant", 16'(rd_grant), 16'd0);
        chk("reset frame_valid", 16'(frame_valid), 16'd0);
        chk("reset frame_len", 16'(frame_len), 16'd0);
        chk("reset frame_swap", 16'(frame_swap), 16'd0);
        chk("reset rd_valid", 16'(rd_valid), 16'd0);
        chk("reset rd_data", 16'(rd_data), 16'd0);
        chk("reset state", 16'(dut.state_reg), 16'(ST_IDLE));
        rd_req = 2'b00;
        reset  = 1'b0;
        step(1);

        // Test 1: simple frame committed by idle timeout
        strobe(0, 8'h00, 1'b0);
        strobe(1, 8'h11, 1'b0);
        strobe(2, 8'h22, 1'b0);
        strobe(3, 8'h33, 1'b0);
        wait_timeout(1'b1);
        chk("t1 swap_cnt", 16'(swap_cnt), 16'd1);
        chk("t1 frame_valid", 16'(frame_valid), 16'd1);
        chk("t1 frame_len", 16'(frame_len), 16'd3);
        read(0, 2, 8'h22);
        read(1, 3, 8'h33);

        // Test 2: back-to-back frames committed by the next start code
        strobe(0, 8'h00, 1'b0);
        strobe(1, 8'hAA, 1'b0);
        strobe(0, 8'h00, 1'b1);
        chk("t2 frame_len a", 16'(frame_len), 16'd1);
        read(0, 1, 8'hAA);
        strobe(1, 8'h55, 1'b0);
        strobe(0, 8'h00, 1'b1);
        read(0, 1, 8'h55);
        chk("t2 swap_cnt", 16'(swap_cnt), 16'd3);

        // Test 3: start-code-only frame discarded, non-zero start code skipped
        strobe(0, 8'hCC, 1'b0);
        strobe(1, 8'h99, 1'b0);
        wait_timeout(1'b0);
        chk("t3 swap_cnt", 16'(swap_cnt), 16'd3);
        chk("t3 state", 16'(dut.state_reg), 16'(ST_IDLE));
        read(0, 2, 8'h22);
        read(1, 1, 8'h55);

        // Test 4: both readers requesting alternate, starting with reader 0
        rd_addr0 = CW'(2);
        rd_addr1 = CW'(3);
        for (int i = 0; i < 6; i++) begin
            rd_req = 2'b11;
            @(negedge clock);
            chk($sformatf("t4 grant %0d", i), 16'(rd_grant), (i % 2 == 0) ? 16'h1 : 16'h2);
            @(posedge clock);
            #1;
            chk($sformatf("t4 valid %0d", i), 16'(rd_valid), (i % 2 == 0) ? 16'h1 : 16'h2);
            chk($sformatf("t4 data %0d", i), 16'(rd_data), (i % 2 == 0) ? 16'h22 : 16'h33);
        end
        rd_req = 2'b00;

        // Test 5: read granted in the swap cycle sees the old frame
        strobe(0, 8'h00, 1'b0);
        strobe(1, 8'h77, 1'b0);
        rx_channel = '0;
        rx_data    = 8'h00;
        rx_strobe  = 1'b1;
        rd_addr0   = CW'(1);
        rd_req     = 2'b01;
        @(negedge clock);
        chk("t5 swap", 16'(frame_swap), 16'd1);
        chk("t5 grant a", 16'(rd_grant), 16'd1);
        @(posedge clock);
        #1;
        rx_strobe = 1'b0;
        chk("t5 valid a", 16'(rd_valid), 16'd1);
        chk("t5 old data", 16'(rd_data), 16'h55);
        @(negedge clock);
        chk("t5 grant b", 16'(rd_grant), 16'd1);
        @(posedge clock);
        #1;
        rd_req = 2'b00;
        chk("t5 valid b", 16'(rd_valid), 16'd1);
        chk("t5 new data", 16'(rd_data), 16'h77);
        chk("t5 frame_len", 16'(frame_len), 16'd1);

        // Test 6: reset mid-frame discards it; a later frame swaps normally
        for (int ch = 1; ch <= 10; ch++) begin
            strobe(ch, 8'(ch * 3), 1'b0);
        end
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        @(negedge clock);
        chk("t6 frame_valid", 16'(frame_valid), 16'd0);
        chk("t6 frame_len", 16'(frame_len), 16'd0);
        chk("t6 state", 16'(dut.state_reg), 16'(ST_IDLE));
        step(1);
        strobe(7, 8'hEE, 1'b0);
        strobe(0, 8'h00, 1'b0);
        strobe(1, 8'h5A, 1'b0);
        strobe(2, 8'hA5, 1'b0);
        wait_timeout(1'b1);
        chk("t6 swap_cnt", 16'(swap_cnt), 16'd5);
        chk("t6 frame_valid b", 16'(frame_valid), 16'd1);
        chk("t6 frame_len b", 16'(frame_len), 16'd2);
        read(0, 2, 8'hA5);
        read(1, 1, 8'h5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
